// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead block per stage,
// carry and unconsumed operand bits registered stage to stage, global-stall valid/ready.
module cla_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NUM_BLK = WIDTH / BLOCK;

   // Every carry is a flat sum-of-products of g/p terms and c0, no ripple through c[i].
   function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] gen,
                                                  input logic [BLOCK-1:0] prp,
                                                  input logic             c0);
      logic [BLOCK:0] cc;
      logic           term;
      logic           acc;
      cc    = '0;
      cc[0] = c0;
      for (int i = 0; i < BLOCK; i++) begin
         acc = c0;
         for (int j = 0; j <= i; j++) acc &= prp[j];
         for (int j = 0; j <= i; j++) begin
            term = gen[j];
            for (int m = j + 1; m <= i; m++) term &= prp[m];
            acc |= term;
         end
         cc[i+1] = acc;
      end
      return cc;
   endfunction

   logic             advance;
   logic             rdy_d;
   logic             rdy_q;
   logic [WIDTH-1:0] b_eff;

   always_comb begin
      advance  = ~out_valid | out_ready;
      in_ready = rdy_q & advance;
      rdy_d    = 1'b1;
      b_eff    = sub ? ~b : b;
   end

   // Holds in_ready low for the first cycle after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_q <= 1'b0;
      else     rdy_q <= rdy_d;
   end

   for (genvar k = 0; k < NUM_BLK; k++) begin : g_stg
      localparam int REM = WIDTH - (k + 1) * BLOCK;
      localparam int SW  = (k + 1) * BLOCK;

      logic             valid_in;
      logic             c_in;
      logic             load;
      logic [BLOCK-1:0] a_blk;
      logic [BLOCK-1:0] b_blk;
      logic [BLOCK-1:0] g;
      logic [BLOCK-1:0] p;
      logic [BLOCK-1:0] blk_sum;
      logic [BLOCK:0]   c;
      logic [SW-1:0]    sum_new;
      logic [SW-1:0]    sum_d;
      logic [SW-1:0]    sum_q;
      logic             valid_d;
      logic             valid_q;
      logic             carry_d;
      logic             carry_q;

      if (k == 0) begin : g_src
         always_comb begin
            valid_in = in_valid & rdy_q;
            a_blk    = a[BLOCK-1:0];
            b_blk    = b_eff[BLOCK-1:0];
            c_in     = sub | cin;
         end
      end else begin : g_src
         always_comb begin
            valid_in = g_stg[k-1].valid_q;
            a_blk    = g_stg[k-1].g_ops.a_q[BLOCK-1:0];
            b_blk    = g_stg[k-1].g_ops.b_q[BLOCK-1:0];
            c_in     = g_stg[k-1].carry_q;
         end
      end

      always_comb begin
         g       = a_blk & b_blk;
         p       = a_blk ^ b_blk;
         c       = cla_carries(g, p, c_in);
         blk_sum = p ^ c[BLOCK-1:0];
      end

      if (k == 0) begin : g_sum
         always_comb sum_new = blk_sum;
      end else begin : g_sum
         always_comb sum_new = {blk_sum, g_stg[k-1].sum_q};
      end

      // Data only loads with a valid token, so idle X on the inputs never reaches sum.
      always_comb begin
         load    = advance & valid_in;
         valid_d = advance ? valid_in : valid_q;
         carry_d = load ? c[BLOCK] : carry_q;
         sum_d   = load ? sum_new : sum_q;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
         end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
         end
      end

      if (REM > 0) begin : g_ops
         logic [REM-1:0] a_nxt;
         logic [REM-1:0] b_nxt;
         logic [REM-1:0] a_d;
         logic [REM-1:0] a_q;
         logic [REM-1:0] b_d;
         logic [REM-1:0] b_q;

         if (k == 0) begin : g_opsrc
            always_comb begin
               a_nxt = a[WIDTH-1:BLOCK];
               b_nxt = b_eff[WIDTH-1:BLOCK];
            end
         end else begin : g_opsrc
            always_comb begin
               a_nxt = g_stg[k-1].g_ops.a_q[REM+BLOCK-1:BLOCK];
               b_nxt = g_stg[k-1].g_ops.b_q[REM+BLOCK-1:BLOCK];
            end
         end

         always_comb begin
            a_d = load ? a_nxt : a_q;
            b_d = load ? b_nxt : b_q;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

      if (k == NUM_BLK - 1) begin : g_out
         logic ovf_d;
         logic ovf_q;

         always_comb ovf_d = load ? (c[BLOCK-1] ^ c[BLOCK]) : ovf_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) ovf_q <= 1'b0;
            else     ovf_q <= ovf_d;
         end

         always_comb begin
            out_valid = valid_q;
            sum       = sum_q;
            cout      = carry_q;
            ovf       = ovf_q;
         end
      end
   end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed and scoreboarded checks of cla_adder_pipe at 16/4, 4/4 and 32/8.
module tb_cla_adder_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;

   logic        w4_in_valid, w4_in_ready, w4_cin, w4_sub, w4_out_valid, w4_out_ready, w4_cout, w4_ovf;
   logic [3:0]  w4_a, w4_b, w4_sum;

   logic        w32_in_valid, w32_in_ready, w32_cin, w32_sub, w32_out_valid, w32_out_ready, w32_cout, w32_ovf;
   logic [31:0] w32_a, w32_b, w32_sum;

   cla_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf));

   cla_adder_pipe #(.WIDTH(4), .BLOCK(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready), .a(w4_a), .b(w4_b),
      .cin(w4_cin), .sub(w4_sub), .out_valid(w4_out_valid), .out_ready(w4_out_ready), .sum(w4_sum),
      .cout(w4_cout), .ovf(w4_ovf));

   cla_adder_pipe #(.WIDTH(32), .BLOCK(8)) dut32 (
      .clk(clk), .rst(rst), .in_valid(w32_in_valid), .in_ready(w32_in_ready), .a(w32_a), .b(w32_b),
      .cin(w32_cin), .sub(w32_sub), .out_valid(w32_out_valid), .out_ready(w32_out_ready), .sum(w32_sum),
      .cout(w32_cout), .ovf(w32_ovf));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {ovf, cout, sum} for a w-bit add (a+b+cin) or subtract (a+~b+1).
   function automatic logic [65:0] ref_model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                             input logic ci, input logic sb);
      logic [64:0] full;
      logic [63:0] mask, be, s;
      logic        co, ov;
      mask = (64'd1 << w) - 64'd1;
      be   = sb ? (~bv & mask) : bv;
      full = {1'b0, av} + {1'b0, be} + {64'd0, (sb | ci)};
      s    = full[63:0] & mask;
      co   = full[w];
      ov   = (av[w-1] == be[w-1]) && (s[w-1] != av[w-1]);
      return {ov, co, s};
   endfunction

   task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
      int lat;
      a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      for (int i = 0; i < 5 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; a = 'x; b = 'x; cin = 1'bx; sub = 1'bx;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      // Accepted on edge N, visible after edge N+3 for four blocks.
      chk({tag, "_latency"}, lat, 3);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"}, ovf, eo);
      @(posedge clk); #1;
   endtask

   logic [65:0] q16[$];
   logic [65:0] q4[$];
   logic [65:0] q32[$];
   logic [65:0] exp_v;
   logic [15:0] hold_s;
   logic        hold_c, hold_o, stalled_prev, accepted;
   int          sent, got, vcount, idx;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; a = 'x; b = 'x; cin = 1'bx; sub = 1'bx;
      w4_in_valid = 1'b0; w4_out_ready = 1'b1; w4_a = '0; w4_b = '0; w4_cin = 1'b0; w4_sub = 1'b0;
      w32_in_valid = 1'b0; w32_out_ready = 1'b1; w32_a = '0; w32_b = '0; w32_cin = 1'b0; w32_sub = 1'b0;

      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 0);

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("in_ready_before_first_edge", in_ready, 0);
      @(posedge clk); #1;
      chk("in_ready_after_release", in_ready, 1);

      // Idle bubbles with X operands must leave the outputs clean.
      repeat (3) @(posedge clk);
      #1;
      chk("idle_x_sum", sum, 0);
      chk("idle_x_out_valid", out_valid, 0);

      do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
      do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      do_op("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
      do_op("sub_ignores_cin", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Eight random sets streamed with a three-cycle output stall.
      sent = 0; got = 0; stalled_prev = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         out_ready = !(cyc >= 5 && cyc <= 7);
         if (sent < 8 && !in_valid) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
         end
         #1;
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            if (stalled_prev) begin
               chk("stall_sum_stable", sum, hold_s);
               chk("stall_cout_stable", cout, hold_c);
               chk("stall_ovf_stable", ovf, hold_o);
               chk("stall_valid_stable", out_valid, 1);
            end
            hold_s = sum; hold_c = cout; hold_o = ovf; stalled_prev = 1'b1;
         end else begin
            stalled_prev = 1'b0;
         end
         if (out_valid && out_ready) begin
            chk("stream_no_extra", q16.size() != 0, 1);
            if (q16.size() != 0) begin
               exp_v = q16.pop_front();
               chk("stream_sum", sum, exp_v[15:0]);
               chk("stream_cout", cout, exp_v[64]);
               chk("stream_ovf", ovf, exp_v[65]);
            end
            got++;
         end
         accepted = in_valid && in_ready;
         if (accepted) begin
            q16.push_back(ref_model(16, {48'd0, a}, {48'd0, b}, cin, sub));
            sent++;
         end
         @(posedge clk); #1;
         if (accepted) in_valid = 1'b0;
      end
      chk("stream_results", got, 8);
      chk("stream_sent", sent, 8);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("stream_drained", out_valid, 0);

      // Three sets in flight, then reset between edges.
      for (int i = 0; i < 3; i++) begin
         a = 16'($urandom) | 16'h0100; b = 16'($urandom); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      vcount = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) vcount++;
      end
      chk("midrst_no_ghost", vcount, 0);
      do_op("after_rst", 16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0);

      // WIDTH=4/BLOCK=4: exhaustive a, b over add cin=0, add cin=1, sub (cin=1 ignored).
      idx = 0; got = 0;
      for (int cyc = 0; cyc < 2000 && got < 768; cyc++) begin
         if (idx < 768) begin
            w4_a = 4'(idx); w4_b = 4'(idx >> 4);
            w4_cin = ((idx >> 8) != 0); w4_sub = ((idx >> 8) == 2);
            w4_in_valid = 1'b1;
         end else begin
            w4_in_valid = 1'b0;
         end
         #1;
         if (w4_out_valid && w4_out_ready) begin
            if (q4.size() != 0) begin
               exp_v = q4.pop_front();
               chk("w4_sum", w4_sum, exp_v[3:0]);
               chk("w4_cout", w4_cout, exp_v[64]);
               chk("w4_ovf", w4_ovf, exp_v[65]);
            end else begin
               chk("w4_no_extra", 0, 1);
            end
            got++;
         end
         if (w4_in_valid && w4_in_ready) begin
            q4.push_back(ref_model(4, {60'd0, w4_a}, {60'd0, w4_b}, w4_cin, w4_sub));
            idx++;
         end
         @(posedge clk); #1;
      end
      chk("w4_results", got, 768);
      w4_in_valid = 1'b0;

      // WIDTH=32/BLOCK=8: random operands and modes with random backpressure.
      idx = 0; got = 0;
      for (int cyc = 0; cyc < 6000 && got < 2000; cyc++) begin
         w32_out_ready = ($urandom_range(0, 3) != 0);
         if (idx < 2000 && !w32_in_valid) begin
            w32_a = $urandom; w32_b = $urandom;
            w32_cin = 1'($urandom); w32_sub = ($urandom_range(0, 2) == 2);
            w32_in_valid = 1'b1;
         end
         #1;
         if (w32_out_valid && w32_out_ready) begin
            if (q32.size() != 0) begin
               exp_v = q32.pop_front();
               chk("w32_sum", w32_sum, exp_v[31:0]);
               chk("w32_cout", w32_cout, exp_v[64]);
               chk("w32_ovf", w32_ovf, exp_v[65]);
            end else begin
               chk("w32_no_extra", 0, 1);
            end
            got++;
         end
         accepted = w32_in_valid && w32_in_ready;
         if (accepted) begin
            q32.push_back(ref_model(32, {32'd0, w32_a}, {32'd0, w32_b}, w32_cin, w32_sub));
            idx++;
         end
         @(posedge clk); #1;
         if (accepted) w32_in_valid = 1'b0;
      end
      chk("w32_results", got, 2000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
